// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the two-port memory arbiter: FSM state encoding, the
// requester identifier, and small mapping helpers used by the top level and
// by the grant-selection sub-module.
// Optional feature macro: MEM_PORT_ARBITER_RR_EN (round-robin on contention).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Arbiter FSM state, kept as plain encoded constants so the encoding is
    // visible in waveforms and stable for any legacy code that decodes it.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t SERVE_A = 2'd1;
    localparam arb_state_t SERVE_B = 2'd2;

    // Requester identity: A is instruction fetch, B is data access.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_t;

    // State that serves a given port.
    function automatic arb_state_t serve_state(input arb_port_t p);
        return (p == PORT_B) ? SERVE_B : SERVE_A;
    endfunction

    // The port that is not p; used to alternate grants under contention.
    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arb_select.sv
// -----------------------------------------------------------------------------
// mem_port_arb_select
// Combinational grant decision for the memory port arbiter. Given the two
// request lines it names the port that wins the next grant.
//   - default build: fixed priority, data port B over fetch port A, so data
//     accesses retire before the next instruction fetch.
//   - MEM_PORT_ARBITER_RR_EN defined: on contention the port that did not win
//     the previous grant wins; a lone requester always wins immediately.
// o_valid flags that at least one port is requesting; o_grant is only
// meaningful while o_valid is high.
// -----------------------------------------------------------------------------
module mem_port_arb_select
    import mem_port_arbiter_pkg::*;
(
    input  logic      i_req_a,
    input  logic      i_req_b,
`ifdef MEM_PORT_ARBITER_RR_EN
    input  arb_port_t i_last_grant,
`endif
    output arb_port_t o_grant,
    output logic      o_valid
);

    assign o_valid = i_req_a | i_req_b;

    // Pick the winning port from the current requests.
    always_comb begin
        // NOTE: default first so every path assigns o_grant; no latch is inferred.
        o_grant = PORT_A;
`ifdef MEM_PORT_ARBITER_RR_EN
        if (i_req_a && i_req_b) begin
            o_grant = other_port(i_last_grant);
        end else if (i_req_b) begin
            o_grant = PORT_B;
        end
`else
        if (i_req_b) begin
            o_grant = PORT_B;
        end
`endif
    end

endmodule : mem_port_arb_select

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported cache/memory between the CPU's instruction-fetch
// port (A) and data port (B). One port is granted at a time; the grant is held
// until the memory completes (mem_resp) or the granted port withdraws its
// request. While a port is served its control, address and data are passed
// straight through to the memory, and the completion pulse is steered back to
// that port only. Between grants the arbiter always spends at least one cycle
// in IDLE, so the memory strobes drop for a cycle between transactions.
// Read data is broadcast to both ports; it is valid only with the matching
// resp pulse.
// Optional feature macro: MEM_PORT_ARBITER_RR_EN selects round-robin
// arbitration on simultaneous requests instead of fixed B-over-A priority.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // Port A: instruction fetch
    input  logic                  read_a,
    input  logic                  write_a,
    input  logic [MASK_WIDTH-1:0] wmask_a,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  resp_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    // Port B: data access
    input  logic                  read_b,
    input  logic                  write_b,
    input  logic [MASK_WIDTH-1:0] wmask_b,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  resp_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    // Shared memory side
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic       w_req_a;
    logic       w_req_b;
    logic       w_any_req;
    arb_port_t  w_grant;

    // A port is requesting whenever it asks for either a read or a write.
    assign w_req_a = read_a | write_a;
    assign w_req_b = read_b | write_b;

`ifdef MEM_PORT_ARBITER_RR_EN
    arb_port_t r_last_grant;

    mem_port_arb_select u_select (
        .i_req_a      (w_req_a),
        .i_req_b      (w_req_b),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_any_req)
    );
`else
    mem_port_arb_select u_select (
        .i_req_a (w_req_a),
        .i_req_b (w_req_b),
        .o_grant (w_grant),
        .o_valid (w_any_req)
    );
`endif

    // Next grant: IDLE grants any requester; a served port is released on
    // completion or when it withdraws its request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = serve_state(w_grant);
                end
            end
            SERVE_A: begin
                if (mem_resp || !w_req_a) begin
                    w_state_next = IDLE;
                end
            end
            SERVE_B: begin
                if (mem_resp || !w_req_b) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Grant register; synchronous reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef MEM_PORT_ARBITER_RR_EN
    // Remember who won the most recent grant so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= PORT_A;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    // Steer the granted port to the memory and the completion back to it.
    // Reset forces the memory side quiet in the same cycle it is asserted.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_address = '0;
        mem_wdata   = '0;
        resp_a      = 1'b0;
        resp_b      = 1'b0;
        if (!rst) begin
            case (r_state)
                SERVE_A: begin
                    mem_read    = read_a;
                    mem_write   = write_a;
                    mem_wmask   = wmask_a;
                    mem_address = address_a;
                    mem_wdata   = wdata_a;
                    // A withdrawn request gets no completion even if the
                    // memory answers in that same cycle.
                    resp_a      = mem_resp & w_req_a;
                end
                SERVE_B: begin
                    mem_read    = read_b;
                    mem_write   = write_b;
                    mem_wmask   = wmask_b;
                    mem_address = address_b;
                    mem_wdata   = wdata_b;
                    resp_b      = mem_resp & w_req_b;
                end
                default: begin
                    // IDLE: memory side stays quiet and mem_resp is ignored.
                end
            endcase
        end
    end

    // Read data is broadcast; each port qualifies it with its own resp.
    assign rdata_a = mem_rdata;
    assign rdata_b = mem_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A behavioural model tracks which
// port currently owns the memory and who won last; directed scenarios and a
// randomized run compare the DUT against it and against literal values.
// Honours MEM_PORT_ARBITER_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = DW / 8;
    localparam int BW = 2 + MW + AW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_a, write_a, read_b, write_b;
    logic [MW-1:0] wmask_a, wmask_b;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          resp_a, resp_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          mem_read, mem_write;
    logic [MW-1:0] mem_wmask;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp;
    logic [DW-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner 0 = nobody, 1 = port A, 2 = port B; last_b = B won last.
    int            owner  = 0;
    int            last_b = 0;
    logic [BW-1:0] exp_mem;
    logic          exp_resp_a, exp_resp_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_a      (read_a),
        .write_a     (write_a),
        .wmask_a     (wmask_a),
        .address_a   (address_a),
        .wdata_a     (wdata_a),
        .resp_a      (resp_a),
        .rdata_a     (rdata_a),
        .read_b      (read_b),
        .write_b     (write_b),
        .wmask_b     (wmask_b),
        .address_b   (address_b),
        .wdata_b     (wdata_b),
        .resp_b      (resp_b),
        .rdata_b     (rdata_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    // Expected combinational outputs for the current cycle.
    function automatic void predict();
        exp_mem    = '0;
        exp_resp_a = 1'b0;
        exp_resp_b = 1'b0;
        if (!rst) begin
            if (owner == 1) begin
                exp_mem    = {read_a, write_a, wmask_a, address_a, wdata_a};
                exp_resp_a = mem_resp & (read_a | write_a);
            end else if (owner == 2) begin
                exp_mem    = {read_b, write_b, wmask_b, address_b, wdata_b};
                exp_resp_b = mem_resp & (read_b | write_b);
            end
        end
    endfunction

    // Advance one clock and update who owns the memory afterwards.
    task automatic tick();
        logic ra, rb;
        @(posedge clk);
        ra = read_a | write_a;
        rb = read_b | write_b;
        if (rst) begin
            owner  = 0;
            last_b = 0;
        end else if (owner == 0) begin
            if (ra && rb) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                owner = (last_b != 0) ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (rb) begin
                owner = 2;
            end else if (ra) begin
                owner = 1;
            end
            if (owner != 0) last_b = (owner == 2) ? 1 : 0;
        end else if (mem_resp || !((owner == 1) ? ra : rb)) begin
            owner = 0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        read_a = 0; write_a = 0; wmask_a = '0; address_a = '0; wdata_a = '0;
        read_b = 0; write_b = 0; wmask_b = '0; address_b = '0; wdata_b = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1; read_a = 1; address_a = 16'h1111; mem_rdata = 16'hA5C3;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_tests++;
            if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_mem_outputs: got %h expected 0",
                         {mem_read, mem_write, mem_wmask, mem_address, mem_wdata});
            end
            n_tests++;
            if ({resp_a, resp_b} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_resp: got %b expected 00", {resp_a, resp_b});
            end
            n_tests++;
            if (rdata_a !== 16'hA5C3 || rdata_b !== 16'hA5C3) begin
                n_fail++;
                $display("FAIL reset_rdata: got %h/%h expected a5c3", rdata_a, rdata_b);
            end
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read();
        read_a = 1; address_a = 16'h3000;
        #2;
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_strobe: mem_read=%b expected 0", mem_read);
        end
        tick();
        #2;
        n_tests++;
        if (mem_read !== 1'b1 || mem_address !== 16'h3000 || resp_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe: read=%b addr=%h resp_a=%b expected 1/3000/0",
                     mem_read, mem_address, resp_a);
        end
        tick();
        mem_resp = 1; mem_rdata = 16'h1234;
        #2;
        n_tests++;
        if (resp_a !== 1'b1 || rdata_a !== 16'h1234 || resp_b !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: resp_a=%b rdata_a=%h resp_b=%b expected 1/1234/0",
                     resp_a, rdata_a, resp_b);
        end
        tick();
        read_a = 0; mem_resp = 0;
        #2;
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++; $display("FAIL single_return_idle: mem_read=%b expected 0", mem_read);
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        read_a = 1; address_a = 16'h3000;
        write_b = 1; address_b = 16'h4000; wdata_b = 16'hBEEF; wmask_b = 2'b01;
        #2;
        n_tests++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_fail++; $display("FAIL prio_idle: strobes=%b expected 00", {mem_read, mem_write});
        end
        tick();
        mem_resp = 1;
        #2;
        n_tests++;
        if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !==
            {1'b0, 1'b1, 2'b01, 16'h4000, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL prio_b_first: rd=%b wr=%b mask=%b addr=%h wdata=%h expected 0/1/01/4000/beef",
                     mem_read, mem_write, mem_wmask, mem_address, mem_wdata);
        end
        n_tests++;
        if ({resp_a, resp_b} !== 2'b01) begin
            n_fail++; $display("FAIL prio_b_resp: resp a/b=%b expected 01", {resp_a, resp_b});
        end
        tick();
        write_b = 0; mem_resp = 0;
        #2;
        n_tests++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_fail++; $display("FAIL prio_gap: strobes=%b expected 00", {mem_read, mem_write});
        end
        tick();
        mem_resp = 1;
        #2;
        n_tests++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h3000 || resp_a !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_a_second: rd=%b wr=%b addr=%h resp_a=%b expected 1/0/3000/1",
                     mem_read, mem_write, mem_address, resp_a);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int grants[$];
        int exp_order[4];
`ifdef MEM_PORT_ARBITER_RR_EN
        exp_order = '{2, 1, 2, 1};
`else
        exp_order = '{2, 2, 2, 2};
`endif
        read_a = 1; address_a = 16'h0A0A;
        read_b = 1; address_b = 16'h0B0B;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            mem_resp = 0;
            #1;
            mem_resp = mem_read | mem_write;
            #1;
            if (resp_b) grants.push_back(2);
            else if (resp_a) grants.push_back(1);
            tick();
        end
        n_tests++;
        if (grants.size() != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d grants expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (grants[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got port %0d expected port %0d (1=A 2=B)",
                             i, grants[i], exp_order[i]);
                end
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_withdrawal();
        read_b = 1; address_b = 16'h7777;
        #2;
        tick();
        read_b = 0; read_a = 1; address_a = 16'h5A5A;
        #2;
        n_tests++;
        if ({mem_read, resp_a, resp_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL withdraw_drop: read/resp_a/resp_b=%b expected 000", {mem_read, resp_a, resp_b});
        end
        tick();
        #2;
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_idle: mem_read=%b expected 0", mem_read);
        end
        tick();
        mem_resp = 1;
        #2;
        n_tests++;
        if (mem_read !== 1'b1 || mem_address !== 16'h5A5A || resp_a !== 1'b1 || resp_b !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_then_a: rd=%b addr=%h resp_a=%b resp_b=%b expected 1/5a5a/1/0",
                     mem_read, mem_address, resp_a, resp_b);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        read_a = 1; address_a = 16'h2222;
        #2;
        tick();
        #2;
        n_tests++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_serving: mem_read=%b expected 1", mem_read);
        end
        rst = 1;
        #1;
        n_tests++;
        if (mem_read !== 1'b0 || mem_address !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_drop: rd=%b addr=%h expected 0/0000", mem_read, mem_address);
        end
        tick();
        rst = 0; read_a = 0; mem_resp = 1;
        #2;
        n_tests++;
        if ({mem_read, resp_a, resp_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_late_resp: read/resp_a/resp_b=%b expected 000", {mem_read, resp_a, resp_b});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious();
        mem_resp = 1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_tests++;
            if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0000) begin
                n_fail++;
                $display("FAIL spurious_resp: resp_a/resp_b/rd/wr=%b expected 0000",
                         {resp_a, resp_b, mem_read, mem_write});
            end
            tick();
        end
        mem_resp = 0;
        read_b = 1; address_b = 16'h0C0C;
        #2;
        tick();
        #2;
        n_tests++;
        if (mem_read !== 1'b1 || mem_address !== 16'h0C0C) begin
            n_fail++;
            $display("FAIL spurious_state: rd=%b addr=%h expected 1/0c0c", mem_read, mem_address);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic act_a = 0, act_b = 0, done_a = 0, done_b = 0;
        int   r;
        for (int c = 0; c < 600; c++) begin
            if (done_a) begin read_a = 0; write_a = 0; act_a = 0; end
            if (done_b) begin read_b = 0; write_b = 0; act_b = 0; end
            if (!act_a && $urandom_range(0, 2) == 0) begin
                act_a = 1; r = $urandom_range(0, 9);
                read_a = (r <= 5) || (r == 9); write_a = (r >= 6);
                address_a = AW'($urandom); wdata_a = DW'($urandom); wmask_a = MW'($urandom);
            end else if (act_a && $urandom_range(0, 15) == 0) begin
                act_a = 0; read_a = 0; write_a = 0;
            end
            if (!act_b && $urandom_range(0, 2) == 0) begin
                act_b = 1; r = $urandom_range(0, 9);
                read_b = (r <= 5) || (r == 9); write_b = (r >= 6);
                address_b = AW'($urandom); wdata_b = DW'($urandom); wmask_b = MW'($urandom);
            end else if (act_b && $urandom_range(0, 15) == 0) begin
                act_b = 0; read_b = 0; write_b = 0;
            end
            rst       = ($urandom_range(0, 63) == 0);
            mem_resp  = ($urandom_range(0, 1) == 1);
            mem_rdata = DW'($urandom);
            #2;
            predict();
            n_tests++;
            if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !== exp_mem) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: got %h expected %h", c,
                         {mem_read, mem_write, mem_wmask, mem_address, mem_wdata}, exp_mem);
            end
            n_tests++;
            if ({resp_a, resp_b} !== {exp_resp_a, exp_resp_b}) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got a/b=%b expected %b", c,
                         {resp_a, resp_b}, {exp_resp_a, exp_resp_b});
            end
            n_tests++;
            if (rdata_a !== mem_rdata || rdata_b !== mem_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h", c, rdata_a, rdata_b, mem_rdata);
            end
            done_a = exp_resp_a;
            done_b = exp_resp_b;
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_back_to_back();
        test_withdrawal();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
